chimera_cluster_pwr_seq: RTL and testbench
==========================================

# chimera_cluster_pwr_seq

Per-cluster clock/reset sequencer between the Chimera top-level register file, which provides per-cluster enable bits, and the external Snitch clusters.
- Converts each software-written enable level into a staggered power-up sequence (clock on, settle, reset release) or power-down sequence (drain, reset assert, hold, clock off).
- Serves one cluster at a time, in round-robin order, to bound clock-enable inrush.

## Interface
- `NumClusters`, default `chimera_pkg::ExtClusters` (5): number of clusters sequenced.
- `ClkSettleCycles`, default 4: cycles between clock enable and reset release; must be ≥1.
- `RstHoldCycles`, default 8: cycles reset is held with the clock running before clock disable; must be ≥1.
- `clk_i` in 1: the single clock.
- `rst_ni` in 1: reset, synchronous, active-low.
- `req_en_i` in NumClusters: target state per cluster (1=on), level, from the top-level register.
- `clu_idle_i` in NumClusters: cluster reports no outstanding AXI/DMA traffic.
- `clu_clk_en_o` out NumClusters: cluster clock-gate enable.
- `clu_rst_no` out NumClusters: cluster reset, active-low, synchronous to `clk_i`.
- `clu_on_o` out NumClusters: cluster is out of reset and usable; register readback.
- `done_o` out NumClusters: one-cycle pulse when a cluster's transition completes.
- `busy_o` out 1: sequencer is not in IDLE.

## Operation
- Reset values: all outputs are 0, state is IDLE, round-robin pointer is 0, counter is 0.
- Mismatch vector: `req_en_i ^ clu_on_o`.
- IDLE: if the mismatch vector is nonzero, select the first set index at or after the pointer, wrapping.
  - Latch the selected index into `sel`. Set the pointer to `sel+1` mod NumClusters.
  - Go to UP if `req_en_i[sel]` is 1, otherwise DRAIN.
- UP:
  - On entry, `clu_clk_en_o[sel]` is 1 and the counter is loaded with `ClkSettleCycles-1`.
  - The counter decrements each cycle. At 0, set `clu_rst_no[sel]` and `clu_on_o[sel]` to 1, pulse `done_o[sel]`, and go to IDLE.
  - UP ignores `req_en_i` changes. A request deasserted meanwhile is served on a later pass.
- DRAIN:
  - Wait for `clu_idle_i[sel]`=1. There is no timeout.
  - If `req_en_i[sel]` returns to 1 first, go to IDLE. Outputs are unchanged and there is no `done_o` pulse.
  - Idle takes priority over abort when both are seen in the same cycle.
  - When idle is sampled 1: clear `clu_rst_no[sel]` and `clu_on_o[sel]`, load the counter with `RstHoldCycles-1`, and go to HOLD.
- HOLD: the counter decrements each cycle. At 0, clear `clu_clk_en_o[sel]`, pulse `done_o[sel]`, and go to IDLE.
- Invariant: `clu_rst_no[i]` is 1 only when `clu_clk_en_o[i]` is 1.
- Widths:
  - Counter width is `$clog2(max(ClkSettleCycles,RstHoldCycles))` bits, minimum 1.
  - Pointer and `sel` are `$clog2(NumClusters)` bits, minimum 1.
  - The pointer wrap from NumClusters-1 to 0 is explicit.
- Reset mid-operation: `rst_ni` low for one edge forces all outputs to 0 at once, with no graceful sequencing. After release, any enable still requested is re-sequenced from scratch.

## Timing
- All outputs are registered. Mismatch seen in IDLE at cycle t gives a state change visible at t+1.
- Power-up, with t = cycle IDLE sees the mismatch:
  - `clu_clk_en_o` rises at t+1.
  - `clu_rst_no`, `clu_on_o` and `done_o` rise at t+1+ClkSettleCycles.
  - `busy_o` is high over t+1..t+ClkSettleCycles.
- Power-down, with d = cycle `clu_idle_i` is sampled 1 in DRAIN:
  - `clu_rst_no` and `clu_on_o` fall at d+1.
  - `clu_clk_en_o` falls and `done_o` pulses at d+1+RstHoldCycles.
- Back-to-back: IDLE at cycle u can select the next cluster, so the next sequence's first output change is at u+1.
- `done_o` is high for exactly one cycle per completed transition and never for an aborted one.

## Structure
- Add to `chimera_pkg`: constants `ClusterClkSettleCycles` and `ClusterRstHoldCycles`, and enum `cluster_pwr_state_e` {IDLE, UP, DRAIN, HOLD}.
- Use the common_cells `lzc` (trailing-zero mode) on the mismatch vector rotated by the pointer to pick the next cluster. No other sub-module.
- The top level instantiates one sequencer with `NumClusters=ExtClusters`. Its outputs feed the per-cluster clock gates and reset synchronisers.

## Test plan
- Reset: hold `rst_ni`=0 for 3 cycles with `req_en_i`=5'h1F -> all outputs 0 and `busy_o`=0 throughout.
- Single power-up: `req_en_i`=5'b00100 at cycle 0 -> `clu_clk_en_o[2]`=1 at cycle 1; `clu_rst_no[2]`, `clu_on_o[2]` and `done_o[2]` pulse at cycle 5; `busy_o` high over cycles 1-4.
- Round-robin: `req_en_i`=5'h1F at cycle 0 -> clocks rise at cycles 1, 6, 11, 16, 21 in cluster order 0..4; all on at 25; pointer wraps to 0.
- Drain-gated power-down: cluster 1 on, `req_en_i[1]`←0 at 0, `clu_idle_i[1]`=1 first at cycle 10 -> reset falls at 11, clock falls and `done_o[1]` pulses at 19.
- Abort: in DRAIN with `clu_idle_i[1]`=0, `req_en_i[1]`←1 at cycle 3 -> IDLE at 4; clock and reset stay 1; no `done_o`.
- Reset mid-UP: `rst_ni`=0 at cycle 2 of a cluster-0 power-up -> all outputs 0 next cycle; after release the full sequence restarts.

Source files
------------

// File: rtl/chimera_cluster_pwr_seq_pkg.sv
// chimera_cluster_pwr_seq_pkg: shared cluster power-sequencing constants and state type
package chimera_cluster_pwr_seq_pkg;
  localparam int ExtClusters = 5;
  localparam int ClusterClkSettleCycles = 4;
  localparam int ClusterRstHoldCycles = 8;
  typedef enum logic [1:0] {IDLE, UP, DRAIN, HOLD} cluster_pwr_state_e;
endpackage

// File: rtl/chimera_cluster_pwr_seq_lzc.sv
// chimera_cluster_pwr_seq_lzc: trailing-zero counter, picks the lowest set bit
module chimera_cluster_pwr_seq_lzc #(
  parameter int Width = 2,
  localparam int CntW = Width > 1 ? $clog2(Width) : 1
) (
  input  logic [Width-1:0] in_i,
  output logic [CntW-1:0]  cnt_o,
  output logic             empty_o
);
  assign empty_o = ~|in_i;
  // scan from the top so the lowest set bit is the last one written
  always_comb begin
    cnt_o = '0;
    for (int i = Width - 1; i >= 0; i--) if (in_i[i]) cnt_o = CntW'(i);
  end
endmodule

// File: rtl/chimera_cluster_pwr_seq.sv
// chimera_cluster_pwr_seq: round-robin per-cluster clock/reset power sequencer
module chimera_cluster_pwr_seq
  import chimera_cluster_pwr_seq_pkg::*;
#(
  parameter int NumClusters = ExtClusters,
  parameter int ClkSettleCycles = ClusterClkSettleCycles,
  parameter int RstHoldCycles = ClusterRstHoldCycles
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NumClusters-1:0] req_en_i,
  input  logic [NumClusters-1:0] clu_idle_i,
  output logic [NumClusters-1:0] clu_clk_en_o,
  output logic [NumClusters-1:0] clu_rst_no,
  output logic [NumClusters-1:0] clu_on_o,
  output logic [NumClusters-1:0] done_o,
  output logic                   busy_o
);
  localparam int MaxCycles = ClkSettleCycles > RstHoldCycles ? ClkSettleCycles : RstHoldCycles;
  localparam int CntW = MaxCycles > 1 ? $clog2(MaxCycles) : 1;
  localparam int PtrW = NumClusters > 1 ? $clog2(NumClusters) : 1;

  cluster_pwr_state_e state;
  logic [PtrW-1:0] ptr, sel, tz, nextSel;
  logic [PtrW:0] selSum;
  logic [CntW-1:0] cnt;
  logic [NumClusters-1:0] mismatch, rotated;
  logic empty;

  assign mismatch = req_en_i ^ clu_on_o;
  assign rotated = NumClusters'({mismatch, mismatch} >> ptr);
  assign busy_o = state != IDLE;

  chimera_cluster_pwr_seq_lzc #(.Width(NumClusters)) i_lzc (
    .in_i   (rotated),
    .cnt_o  (tz),
    .empty_o(empty)
  );

  assign selSum = {1'b0, ptr} + {1'b0, tz};
  assign nextSel = selSum >= (PtrW+1)'(NumClusters) ? PtrW'(selSum - (PtrW+1)'(NumClusters)) : selSum[PtrW-1:0];

  // sequencer FSM: one cluster at a time, all outputs registered
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= IDLE;
      ptr <= '0;
      sel <= '0;
      cnt <= '0;
      clu_clk_en_o <= '0;
      clu_rst_no <= '0;
      clu_on_o <= '0;
      done_o <= '0;
    end else begin
      done_o <= '0;
      case (state)
        IDLE: if (!empty) begin
          sel <= nextSel;
          ptr <= nextSel == PtrW'(NumClusters - 1) ? '0 : nextSel + PtrW'(1);
          if (req_en_i[nextSel]) begin
            clu_clk_en_o[nextSel] <= 1'b1;
            cnt <= CntW'(ClkSettleCycles - 1);
            state <= UP;
          end else begin
            state <= DRAIN;
          end
        end
        UP: if (cnt == '0) begin
          clu_rst_no[sel] <= 1'b1;
          clu_on_o[sel] <= 1'b1;
          done_o[sel] <= 1'b1;
          state <= IDLE;
        end else begin
          cnt <= cnt - CntW'(1);
        end
        DRAIN: if (clu_idle_i[sel]) begin
          clu_rst_no[sel] <= 1'b0;
          clu_on_o[sel] <= 1'b0;
          cnt <= CntW'(RstHoldCycles - 1);
          state <= HOLD;
        end else if (req_en_i[sel]) begin
          state <= IDLE;
        end
        HOLD: if (cnt == '0) begin
          clu_clk_en_o[sel] <= 1'b0;
          done_o[sel] <= 1'b1;
          state <= IDLE;
        end else begin
          cnt <= cnt - CntW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_chimera_cluster_pwr_seq.sv
// tb_chimera_cluster_pwr_seq: directed and randomized checks against a timestamp model
module tb_chimera_cluster_pwr_seq;
  localparam int N = 5;
  localparam int S = 4;
  localparam int H = 8;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic [N-1:0] req = '0, idle = '0;
  logic [N-1:0] clkEn, rstNo, on, done;
  logic busy;

  always #5 clk = ~clk;

  chimera_cluster_pwr_seq #(.NumClusters(N), .ClkSettleCycles(S), .RstHoldCycles(H)) dut (
    .clk_i       (clk),
    .rst_ni      (rstN),
    .req_en_i    (req),
    .clu_idle_i  (idle),
    .clu_clk_en_o(clkEn),
    .clu_rst_no  (rstNo),
    .clu_on_o    (on),
    .done_o      (done),
    .busy_o      (busy)
  );

  int total = 0, bad = 0;
  int ec = 0;
  logic [N-1:0] mClk = '0, mRst = '0, mOn = '0, mDone = '0;
  bit mBusy = 1'b0;
  int mPhase = 0, mSel = 0, mPtr = 0, mEnd = 0;

  task automatic chk(string tag, logic [N-1:0] got, logic [N-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s edge=%0d got=%b exp=%b", tag, ec, got, exp);
    end
  endtask

  // reference: one job at a time, completion scheduled by absolute edge number
  task automatic model();
    logic [N-1:0] mm;
    ec++;
    mDone = '0;
    if (!rstN) begin
      mClk = '0; mRst = '0; mOn = '0; mPtr = 0; mPhase = 0;
    end else if (mPhase == 0) begin
      mm = req ^ mOn;
      for (int k = 0; k < N; k++) begin
        int i = (mPtr + k) % N;
        if (mm[i]) begin
          mSel = i;
          mPtr = (i + 1) % N;
          if (req[i]) begin
            mClk[i] = 1'b1;
            mEnd = ec + S;
            mPhase = 1;
          end else begin
            mPhase = 2;
          end
          break;
        end
      end
    end else if (mPhase == 1) begin
      if (ec == mEnd) begin
        mRst[mSel] = 1'b1; mOn[mSel] = 1'b1; mDone[mSel] = 1'b1; mPhase = 0;
      end
    end else if (mPhase == 2) begin
      if (idle[mSel]) begin
        mRst[mSel] = 1'b0; mOn[mSel] = 1'b0; mEnd = ec + H; mPhase = 3;
      end else if (req[mSel]) begin
        mPhase = 0;
      end
    end else if (ec == mEnd) begin
      mClk[mSel] = 1'b0; mDone[mSel] = 1'b1; mPhase = 0;
    end
    mBusy = mPhase != 0;
  endtask

  task automatic step();
    @(posedge clk);
    model();
    #1;
    chk("clk_en", clkEn, mClk);
    chk("rst_n", rstNo, mRst);
    chk("on", on, mOn);
    chk("done", done, mDone);
    chk("busy", N'(busy), N'(mBusy));
    chk("rst_implies_clk", rstNo & ~clkEn, '0);
  endtask

  initial begin
    logic [N-1:0] expClk, expOn;
    rstN = 1'b0; req = 5'h1F; idle = '0;
    repeat (3) begin
      step();
      chk("reset_outs", clkEn | rstNo | on | done, '0);
      chk("reset_busy", N'(busy), '0);
    end
    rstN = 1'b1; req = 5'b00100;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("up_clk", clkEn, 5'b00100);
      chk("up_rst", rstNo, k == 5 ? 5'b00100 : 5'b0);
      chk("up_done", done, k == 5 ? 5'b00100 : 5'b0);
      chk("up_busy", N'(busy), N'(k < 5));
    end
    req = '0;
    for (int k = 1; k <= 4; k++) begin
      if (k == 4) req = 5'b00100;
      step();
      chk("abort_clk", clkEn, 5'b00100);
      chk("abort_rst", rstNo, 5'b00100);
      chk("abort_done", done, '0);
      chk("abort_busy", N'(busy), N'(k < 4));
    end
    req = '0;
    for (int k = 1; k <= 19; k++) begin
      if (k == 11) idle = 5'h1F;
      step();
      chk("drain_rst", rstNo, k >= 11 ? 5'b0 : 5'b00100);
      chk("drain_clk", clkEn, k >= 19 ? 5'b0 : 5'b00100);
      chk("drain_done", done, k == 19 ? 5'b00100 : 5'b0);
    end
    rstN = 1'b0; step(); rstN = 1'b1; req = 5'h1F;
    for (int k = 1; k <= 25; k++) begin
      step();
      expClk = '0; expOn = '0;
      for (int j = 0; j < N; j++) begin
        expClk[j] = k >= 5 * j + 1;
        expOn[j] = k >= 5 * j + 5;
      end
      chk("rr_clk", clkEn, expClk);
      chk("rr_on", on, expOn);
    end
    rstN = 1'b0; step(); rstN = 1'b1; req = 5'b00001;
    step(); step();
    rstN = 1'b0; step();
    chk("midrst_outs", clkEn | rstNo | on | done, '0);
    rstN = 1'b1; step(); step();
    chk("midrst_restart_clk", clkEn, 5'b00001);
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 24) == 0) req = 5'($urandom);
      idle = 5'($urandom) & 5'($urandom);
      rstN = $urandom_range(0, 499) != 0;
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
